// File: rtl/wb_dest_demux.sv
`default_nettype none
// ============================================================================
// wb_dest_demux : write-back destination one-hot demux with in-flight
//                 destination-register scoreboard for RAW/WAW stall checks.
// Rev 1.0
// ============================================================================
module wb_dest_demux #(
  parameter int AW   = 5,
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DW-1:0]     wb_data,
  output logic [NREG-1:0]   reg_we,
  output logic [DW-1:0]     reg_wdata,
  input  logic [AW-1:0]     qa_rd,
  input  logic [AW-1:0]     qb_rd,
  output logic              qa_busy,
  output logic              qb_busy,
  output logic [NREG-1:0]   busy,
  output logic [AW:0]       inflight_cnt,
  output logic              wb_err
);

  localparam logic [NREG-1:0] c_we_lsb = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] reg_we_q, reg_we_d;
  logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            wb_err_q, wb_err_d;

  logic            w_wb_hit;
  logic            w_issue_acc;

  always_comb begin
    w_wb_hit    = wb_valid && busy_q[wb_rd];
    // A write-back retiring the very register being claimed frees it this cycle.
    issue_ready = !busy_q[issue_rd] || (wb_valid && (wb_rd == issue_rd));
    w_issue_acc = issue_valid && issue_ready;
    qa_busy     = busy_q[qa_rd];
    qb_busy     = busy_q[qb_rd];
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end
    // Set after clear so a same-register claim wins over its retirement.
    if (w_issue_acc) begin
      busy_d[issue_rd] = 1'b1;
    end

    cnt_d = cnt_q + {{AW{1'b0}}, w_issue_acc} - {{AW{1'b0}}, w_wb_hit};

    reg_we_d    = '0;
    reg_wdata_d = reg_wdata_q;
    if (wb_valid) begin
      reg_we_d    = c_we_lsb << wb_rd;
      reg_wdata_d = wb_data;
    end

    wb_err_d = wb_valid && !busy_q[wb_rd];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      reg_we_q    <= '0;
      reg_wdata_q <= '0;
      cnt_q       <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      cnt_q       <= cnt_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign busy         = busy_q;
  assign reg_we       = reg_we_q;
  assign reg_wdata    = reg_wdata_q;
  assign inflight_cnt = cnt_q;
  assign wb_err       = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dest_demux.sv
`default_nettype none
// Bench for wb_dest_demux: directed scenarios plus random traffic, checked by
// a scoreboard fed from a register-level behavioural model.
module tb_wb_dest_demux;

  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic [NREG-1:0] reg_we;
  logic [DW-1:0]   reg_wdata;
  logic [AW-1:0]   qa_rd, qb_rd;
  logic            qa_busy, qb_busy;
  logic [NREG-1:0] busy;
  logic [AW:0]     inflight_cnt;
  logic            wb_err;

  always #5 clk = ~clk;

  wb_dest_demux #(.AW(AW), .NREG(NREG), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .reg_we(reg_we), .reg_wdata(reg_wdata),
    .qa_rd(qa_rd), .qb_rd(qb_rd), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .busy(busy), .inflight_cnt(inflight_cnt), .wb_err(wb_err)
  );

  typedef struct {
    logic rdy;
    logic qa;
    logic qb;
  } comb_t;

  typedef struct {
    logic [NREG-1:0] we;
    logic [DW-1:0]   wdata;
    logic [NREG-1:0] busy;
    logic [AW:0]     cnt;
    logic            err;
  } regx_t;

  comb_t comb_q[$];
  regx_t reg_q[$];

  // Model state: which registers have a pending write, and last written data.
  bit            m_busy[NREG];
  logic [DW-1:0] m_wdata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_wdata = '0;
  endtask

  // Drive one cycle of stimulus and queue what the DUT should show.
  task automatic cycle(input logic iv, input int ird, input logic wv, input int wrd,
                       input logic [DW-1:0] wd, input int qa, input int qb,
                       output logic acc);
    comb_t c;
    regx_t r;
    int    n;
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = AW'(ird);
    wb_valid    = wv;
    wb_rd       = AW'(wrd);
    wb_data     = wd;
    qa_rd       = AW'(qa);
    qb_rd       = AW'(qb);

    c.rdy = !m_busy[ird] || (wv && (wrd == ird));
    c.qa  = m_busy[qa];
    c.qb  = m_busy[qb];
    acc   = iv && c.rdy;

    r.err = wv && !m_busy[wrd];
    r.we  = '0;
    if (wv) begin
      r.we[wrd] = 1'b1;
      m_wdata   = wd;
    end
    r.wdata = m_wdata;
    if (wv)  m_busy[wrd] = 1'b0;
    if (acc) m_busy[ird] = 1'b1;
    n = 0;
    r.busy = '0;
    for (int i = 0; i < NREG; i++) begin
      r.busy[i] = m_busy[i];
      n += int'(m_busy[i]);
    end
    r.cnt = (AW+1)'(n);

    comb_q.push_back(c);
    reg_q.push_back(r);
  endtask

  task automatic idle();
    logic a;
    cycle(1'b0, 0, 1'b0, 0, '0, 0, 0, a);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, busy, '0);
    chk({tag, "_cnt"}, inflight_cnt, '0);
    chk({tag, "_reg_we"}, reg_we, '0);
    chk({tag, "_reg_wdata"}, reg_wdata, '0);
    chk({tag, "_wb_err"}, wb_err, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_clear();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Combinational outputs are checked mid-low-phase, after inputs settle.
  initial begin
    comb_t c;
    forever begin
      @(negedge clk);
      #1;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("issue_ready", issue_ready, c.rdy);
        chk("qa_busy", qa_busy, c.qa);
        chk("qb_busy", qb_busy, c.qb);
      end
    end
  end

  // Registered outputs are checked just after the edge that produces them.
  initial begin
    regx_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        chk("reg_we", reg_we, r.we);
        chk("reg_wdata", reg_wdata, r.wdata);
        chk("busy", busy, r.busy);
        chk("inflight_cnt", inflight_cnt, r.cnt);
        chk("wb_err", wb_err, r.err);
      end
    end
  end

  initial begin
    logic acc;
    logic pend;
    int   prd;
    int   wrd;
    int   nb;
    int   blist[$];
    logic wv;

    reset = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    qa_rd = '0; qb_rd = '0;
    model_clear();
    @(posedge clk);
    #1;
    check_reset_state("power_on");
    #1;
    reset = 1'b0;

    // Reset while registers 3 and 7 are outstanding.
    cycle(1'b1, 3, 1'b0, 0, '0, 3, 7, acc);
    cycle(1'b1, 7, 1'b0, 0, '0, 3, 7, acc);
    idle();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, int'($urandom_range(0, NREG-1)), 1'b0, 0, '0, 3, 7, acc);
    end

    // Claim, stalled reclaim, then release of register 5.
    cycle(1'b1, 5, 1'b0, 0, '0, 5, 0, acc);
    cycle(1'b1, 5, 1'b0, 0, '0, 5, 0, acc);
    cycle(1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 5, 0, acc);
    idle();

    // Same-cycle write-back and claim of register 9.
    cycle(1'b1, 9, 1'b0, 0, '0, 9, 0, acc);
    cycle(1'b1, 9, 1'b1, 9, 32'h1234_5678, 9, 0, acc);
    idle();
    cycle(1'b0, 0, 1'b1, 9, 32'h0BAD_F00D, 9, 0, acc);

    // Fill the scoreboard, probe the full corner, then drain.
    for (int i = 0; i < NREG; i++) cycle(1'b1, i, 1'b0, 0, '0, i, 0, acc);
    cycle(1'b1, 0, 1'b0, 0, '0, 0, 31, acc);
    cycle(1'b1, 31, 1'b1, 31, 32'hA5A5_0031, 31, 0, acc);
    for (int i = 0; i < NREG; i++) cycle(1'b0, 0, 1'b1, i, $urandom, i, 0, acc);

    // Write-back to an idle register.
    cycle(1'b0, 0, 1'b1, 12, 32'hC0FF_EE12, 12, 0, acc);
    idle();
    idle();

    // Query ports have no write-back bypass.
    cycle(1'b1, 4, 1'b0, 0, '0, 4, 6, acc);
    cycle(1'b0, 0, 1'b1, 4, 32'h0000_0444, 4, 6, acc);
    cycle(1'b0, 0, 1'b0, 0, '0, 4, 6, acc);

    // Random traffic; write-back density drifts so the scoreboard fills and empties.
    pend = 1'b0;
    prd  = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        prd  = int'($urandom_range(0, NREG-1));
      end
      wv = (((t / 400) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      blist.delete();
      for (int i = 0; i < NREG; i++) if (m_busy[i]) blist.push_back(i);
      nb = blist.size();
      if (nb == 0 || $urandom_range(0, 9) == 0) wrd = int'($urandom_range(0, NREG-1));
      else wrd = blist[$urandom_range(0, nb-1)];
      cycle(pend, pend ? prd : int'($urandom_range(0, NREG-1)), wv, wrd, $urandom,
            int'($urandom_range(0, NREG-1)), int'($urandom_range(0, NREG-1)), acc);
      if (acc) pend = 1'b0;
    end

    // Reset with a busy scoreboard and pending data discards everything.
    for (int i = 0; i < 6; i++) cycle(1'b1, i + 20, 1'b1, i, $urandom, 20, 0, acc);
    do_reset();
    cycle(1'b1, 20, 1'b0, 0, '0, 20, 21, acc);
    idle();

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
